// File: rtl/uart_prog_loader.sv
// UART boot loader: receives a length-prefixed, little-endian word image and writes it into instruction memory.
// Optional checksum verification of the image is enabled with macro LOADER_CHECKSUM_EN.
module uart_prog_loader #(
   parameter logic [31:0] ADDR_BASE = 32'h0000_0000,
   parameter int          MAX_WORDS = 4096
) (
   input  logic        clk,
   input  logic        Rst_n,
   input  logic        prog,
   input  logic [7:0]  uart_dout,
   input  logic        rx_data_present,
   output logic        rx_ren,
   input  logic        tx_full,
   output logic [7:0]  uart_din,
   output logic        tx_wen,
   output logic [31:0] imem_addr,
   output logic [31:0] imem_din,
   output logic        imem_en,
   output logic        imem_prog_ena,
   output logic        busy,
   output logic        err
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LEN   = 3'd1,
      DATA  = 3'd2,
      WRITE = 3'd3,
      CSUM  = 3'd4,
      ACK   = 3'd5,
      DONE  = 3'd6
   } state_t;

   localparam logic [31:0] MAX_W = 32'(MAX_WORDS);

   state_t      state_q, state_d;
   logic        popped_q, popped_d;
   logic [1:0]  byte_cnt_q, byte_cnt_d;
   logic [15:0] word_cnt_q, word_cnt_d;
   logic [31:0] len_q, len_d;
   logic [31:0] word_q, word_d;
   logic [7:0]  sum_q, sum_d;
   logic        err_q, err_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] din_q, din_d;
   logic [7:0]  tx_byte_q, tx_byte_d;

   logic        pop_state_s;
   logic        rx_ren_s;
   logic [31:0] len_shift_s;
   logic [31:0] word_shift_s;

   // Pops are spaced by popped_q so a FWFT byte is never consumed twice.
   assign pop_state_s  = (state_q == LEN) || (state_q == DATA) || (state_q == CSUM);
   assign rx_ren_s     = prog && pop_state_s && rx_data_present && !popped_q;
   assign len_shift_s  = {uart_dout, len_q[31:8]};
   assign word_shift_s = {uart_dout, word_q[31:8]};

   assign rx_ren        = rx_ren_s;
   assign imem_en       = prog && (state_q == WRITE);
   assign imem_prog_ena = prog && (state_q == WRITE);
   assign tx_wen        = prog && (state_q == ACK) && !tx_full;
   assign busy          = (state_q != IDLE) && (state_q != DONE);
   assign err           = err_q;
   assign imem_addr     = addr_q;
   assign imem_din      = din_q;
   assign uart_din      = tx_byte_q;

   // State and datapath registers.
   always_ff @(posedge clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state_q    <= IDLE;
         popped_q   <= 1'b0;
         byte_cnt_q <= 2'd0;
         word_cnt_q <= 16'd0;
         len_q      <= 32'd0;
         word_q     <= 32'd0;
         sum_q      <= 8'd0;
         err_q      <= 1'b0;
         addr_q     <= 32'd0;
         din_q      <= 32'd0;
         tx_byte_q  <= 8'd0;
      end else begin
         state_q    <= state_d;
         popped_q   <= popped_d;
         byte_cnt_q <= byte_cnt_d;
         word_cnt_q <= word_cnt_d;
         len_q      <= len_d;
         word_q     <= word_d;
         sum_q      <= sum_d;
         err_q      <= err_d;
         addr_q     <= addr_d;
         din_q      <= din_d;
         tx_byte_q  <= tx_byte_d;
      end
   end

   // Next-state and datapath update; prog low overrides everything.
   always_comb begin
      state_d    = state_q;
      popped_d   = rx_ren_s;
      byte_cnt_d = byte_cnt_q;
      word_cnt_d = word_cnt_q;
      len_d      = len_q;
      word_d     = word_q;
      sum_d      = sum_q;
      err_d      = err_q;
      addr_d     = addr_q;
      din_d      = din_q;
      tx_byte_d  = tx_byte_q;
      if (!prog) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               state_d    = LEN;
               byte_cnt_d = 2'd0;
               word_cnt_d = 16'd0;
               sum_d      = 8'd0;
               err_d      = 1'b0;
            end
            LEN: begin
               if (rx_ren_s) begin
                  len_d      = len_shift_s;
                  byte_cnt_d = byte_cnt_q + 2'd1;
                  sum_d      = sum_q + uart_dout;
                  if (byte_cnt_q == 2'd3) begin
                     if ((len_shift_s == 32'd0) || (len_shift_s > MAX_W)) begin
                        err_d     = 1'b1;
                        tx_byte_d = 8'h15;
                        state_d   = ACK;
                     end else begin
                        state_d = DATA;
                     end
                  end else begin
                     state_d = LEN;
                  end
               end else begin
                  state_d = LEN;
               end
            end
            DATA: begin
               if (rx_ren_s) begin
                  word_d     = word_shift_s;
                  byte_cnt_d = byte_cnt_q + 2'd1;
                  sum_d      = sum_q + uart_dout;
                  if (byte_cnt_q == 2'd3) begin
                     din_d   = word_shift_s;
                     addr_d  = ADDR_BASE + {14'd0, word_cnt_q, 2'b00};
                     state_d = WRITE;
                  end else begin
                     state_d = DATA;
                  end
               end else begin
                  state_d = DATA;
               end
            end
            WRITE: begin
               word_cnt_d = word_cnt_q + 16'd1;
               if (({16'd0, word_cnt_q} + 32'd1) < len_q) begin
                  state_d = DATA;
               end else begin
                  state_d = CSUM;
               end
            end
            CSUM: begin
               if (rx_ren_s) begin
`ifdef LOADER_CHECKSUM_EN
                  if (uart_dout != (8'd0 - sum_q)) begin
                     err_d     = 1'b1;
                     tx_byte_d = 8'h15;
                  end else begin
                     tx_byte_d = 8'h06;
                  end
`else
                  tx_byte_d = 8'h06;
`endif
                  state_d = ACK;
               end else begin
                  state_d = CSUM;
               end
            end
            ACK: begin
               if (!tx_full) begin
                  state_d = DONE;
               end else begin
                  state_d = ACK;
               end
            end
            DONE: begin
               state_d = DONE;
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_prog_loader.sv
// Directed bench for uart_prog_loader: FWFT receive FIFO model, imem write and tx logs.
// Built with ADDR_BASE=0x100 and MAX_WORDS=4 so the length limit is cheap to reach.
module tb_uart_prog_loader;

   logic        clk;
   logic        Rst_n;
   logic        prog;
   logic [7:0]  uart_dout;
   logic        rx_data_present;
   logic        rx_ren;
   logic        tx_full;
   logic [7:0]  uart_din;
   logic        tx_wen;
   logic [31:0] imem_addr;
   logic [31:0] imem_din;
   logic        imem_en;
   logic        imem_prog_ena;
   logic        busy;
   logic        err;

   uart_prog_loader #(.ADDR_BASE(32'h0000_0100), .MAX_WORDS(4)) dut (
      .clk(clk), .Rst_n(Rst_n), .prog(prog),
      .uart_dout(uart_dout), .rx_data_present(rx_data_present), .rx_ren(rx_ren),
      .tx_full(tx_full), .uart_din(uart_din), .tx_wen(tx_wen),
      .imem_addr(imem_addr), .imem_din(imem_din),
      .imem_en(imem_en), .imem_prog_ena(imem_prog_ena),
      .busy(busy), .err(err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [7:0]  rx_q[$];
   logic [31:0] wr_addr[$];
   logic [31:0] wr_data[$];
   logic [7:0]  tx_log[$];
   logic        pop_pend;
   int          en_cnt;
   int          pe_cnt;
   int          n_cmp;
   int          n_bad;

   initial begin
      pop_pend        = 1'b0;
      uart_dout       = 8'h00;
      rx_data_present = 1'b0;
   end

   // Pops are applied half a cycle after the strobe, like a registered FIFO read pointer.
   always @(posedge clk) pop_pend <= rx_ren;

   always @(negedge clk) begin
      if (pop_pend && rx_q.size() > 0) void'(rx_q.pop_front());
      rx_data_present = (rx_q.size() > 0);
      uart_dout       = (rx_q.size() > 0) ? rx_q[0] : 8'h00;
      if (imem_en) begin
         wr_addr.push_back(imem_addr);
         wr_data.push_back(imem_din);
         en_cnt++;
      end
      if (imem_prog_ena) pe_cnt++;
      if (tx_wen) tx_log.push_back(uart_din);
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic push_word(input logic [31:0] w, inout logic [7:0] s);
      for (int i = 0; i < 4; i++) begin
         rx_q.push_back(w[8*i +: 8]);
         s = s + w[8*i +: 8];
      end
   endtask

   // Queue a frame; the checksum is only sent when data words follow.
   task automatic load_frame(input logic [31:0] n, input logic [31:0] words[$], input logic bad_csum);
      logic [7:0] s;
      s = 8'd0;
      push_word(n, s);
      foreach (words[k]) push_word(words[k], s);
      if (words.size() > 0) rx_q.push_back((8'd0 - s) ^ (bad_csum ? 8'hFF : 8'h00));
   endtask

   task automatic new_run();
      @(posedge clk); #1;
      prog = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rx_q.delete(); wr_addr.delete(); wr_data.delete(); tx_log.delete();
      en_cnt = 0; pe_cnt = 0;
      prog = 1'b1;
   endtask

   task automatic wait_tx(input int n);
      int cyc;
      cyc = 0;
      while (tx_log.size() < n && cyc < 3000) begin
         @(negedge clk);
         cyc++;
      end
      check_eq("tx_count", tx_log.size(), n);
      repeat (2) @(negedge clk);
   endtask

   task automatic wait_rx_empty();
      int cyc;
      cyc = 0;
      while (rx_q.size() > 0 && cyc < 3000) begin
         @(negedge clk);
         cyc++;
      end
      check_eq("rx_drained", rx_q.size(), 0);
   endtask

   logic [31:0] w[$];

   initial begin
      n_cmp = 0; n_bad = 0; en_cnt = 0; pe_cnt = 0;
      Rst_n = 1'b1; prog = 1'b0; tx_full = 1'b0;
      #2 Rst_n = 1'b0;
      #1;
      check_eq("rst_busy", busy, 0);
      check_eq("rst_err", err, 0);
      check_eq("rst_rx_ren", rx_ren, 0);
      check_eq("rst_tx_wen", tx_wen, 0);
      check_eq("rst_imem_en", imem_en, 0);
      check_eq("rst_imem_addr", imem_addr, 0);
      check_eq("rst_uart_din", uart_din, 0);
      repeat (3) @(posedge clk);
      #1 Rst_n = 1'b1;

      // Single-word frame from the example image.
      new_run();
      w = '{32'h0000_0513};
      load_frame(32'd1, w, 1'b0);
      check_eq("csum_byte_e7", rx_q[8], 32'h0000_00E7);
      wait_tx(1);
      check_eq("f1_writes", wr_addr.size(), 1);
      check_eq("f1_addr", wr_addr[0], 32'h0000_0100);
      check_eq("f1_data", wr_data[0], 32'h0000_0513);
      check_eq("f1_tx", tx_log[0], 32'h06);
      check_eq("f1_busy_done", busy, 0);
      check_eq("f1_err", err, 0);
      check_eq("f1_addr_hold", imem_addr, 32'h0000_0100);
      rx_q.push_back(8'hAA);
      repeat (10) @(negedge clk);
      check_eq("done_no_pop", rx_q.size(), 1);

      // Three words: sequential addresses, one-cycle strobes.
      new_run();
      w = '{32'h1122_3344, 32'hDEAD_BEEF, 32'h0000_0001};
      load_frame(32'd3, w, 1'b0);
      wait_tx(1);
      check_eq("f3_writes", wr_addr.size(), 3);
      check_eq("f3_addr0", wr_addr[0], 32'h0000_0100);
      check_eq("f3_addr1", wr_addr[1], 32'h0000_0104);
      check_eq("f3_addr2", wr_addr[2], 32'h0000_0108);
      check_eq("f3_data1", wr_data[1], 32'hDEAD_BEEF);
      check_eq("f3_data2", wr_data[2], 32'h0000_0001);
      check_eq("f3_prog_ena", pe_cnt, 3);
      check_eq("f3_tx", tx_log[0], 32'h06);

      // Length at the MAX_WORDS limit is accepted.
      new_run();
      w = '{32'd1, 32'd2, 32'd3, 32'd4};
      load_frame(32'd4, w, 1'b0);
      wait_tx(1);
      check_eq("f4_writes", wr_addr.size(), 4);
      check_eq("f4_last_addr", wr_addr[3], 32'h0000_010C);
      check_eq("f4_last_data", wr_data[3], 32'd4);
      check_eq("f4_err", err, 0);

      // Zero length.
      new_run();
      w = {};
      load_frame(32'd0, w, 1'b0);
      wait_tx(1);
      check_eq("n0_writes", en_cnt, 0);
      check_eq("n0_err", err, 1);
      check_eq("n0_tx", tx_log[0], 32'h15);

      // One beyond MAX_WORDS.
      new_run();
      load_frame(32'd5, w, 1'b0);
      wait_tx(1);
      check_eq("n5_writes", en_cnt, 0);
      check_eq("n5_err", err, 1);
      check_eq("n5_tx", tx_log[0], 32'h15);

      // Corrupted checksum byte.
      new_run();
      w = '{32'h0000_0513};
      load_frame(32'd1, w, 1'b1);
      wait_tx(1);
      check_eq("bad_csum_writes", en_cnt, 1);
`ifdef LOADER_CHECKSUM_EN
      check_eq("bad_csum_err", err, 1);
      check_eq("bad_csum_tx", tx_log[0], 32'h15);
`else
      check_eq("bad_csum_err", err, 0);
      check_eq("bad_csum_tx", tx_log[0], 32'h06);
`endif

      // Transmit FIFO full while acknowledging.
      new_run();
      tx_full = 1'b1;
      w = '{32'h0BAD_F00D};
      load_frame(32'd1, w, 1'b0);
      wait_rx_empty();
      repeat (20) @(negedge clk);
      check_eq("txfull_no_wen", tx_log.size(), 0);
      check_eq("txfull_busy", busy, 1);
      @(posedge clk); #1 tx_full = 1'b0;
      @(negedge clk);
      check_eq("txfull_wen_pulse", tx_wen, 1);
      repeat (3) @(negedge clk);
      check_eq("txfull_tx_count", tx_log.size(), 1);
      check_eq("txfull_tx", tx_log[0], 32'h06);
      check_eq("txfull_busy_done", busy, 0);

      // Asynchronous reset mid-frame, then a fresh frame with prog held high.
      new_run();
      w = {};
      load_frame(32'd1, w, 1'b0);
      rx_q.push_back(8'h0D);
      rx_q.push_back(8'hF0);
      wait_rx_empty();
      repeat (2) @(negedge clk);
      check_eq("mid_busy_before", busy, 1);
      @(posedge clk); #3 Rst_n = 1'b0;
      #1;
      check_eq("mid_rst_busy", busy, 0);
      check_eq("mid_rst_addr", imem_addr, 0);
      check_eq("mid_rst_din", imem_din, 0);
      check_eq("mid_rst_uart_din", uart_din, 0);
      check_eq("mid_rst_err", err, 0);
      repeat (2) @(negedge clk);
      rx_q.delete(); wr_addr.delete(); wr_data.delete(); tx_log.delete();
      en_cnt = 0; pe_cnt = 0;
      @(posedge clk); #1 Rst_n = 1'b1;
      w = '{32'hCAFE_F00D};
      load_frame(32'd1, w, 1'b0);
      wait_tx(1);
      check_eq("post_rst_writes", wr_addr.size(), 1);
      check_eq("post_rst_addr", wr_addr[0], 32'h0000_0100);
      check_eq("post_rst_data", wr_data[0], 32'hCAFE_F00D);
      check_eq("post_rst_tx", tx_log[0], 32'h06);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
